// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit widths and target codes produced by route compute.
package noc_pkg;

    localparam int FLIT_RC_W = 23;
    localparam int FLIT_W    = 20;
    localparam int TGT_W     = 3;

    typedef enum logic [TGT_W-1:0] {
        TGT_NONE = 3'd0,
        TGT_CW   = 3'd1,
        TGT_CCW  = 3'd2,
        TGT_UP   = 3'd3,
        TGT_P11  = 3'd4,
        TGT_P10  = 3'd5,
        TGT_P01  = 3'd6,
        TGT_P00  = 3'd7
    } tgt_e;

    function automatic logic [FLIT_W-1:0] strip_target(input logic [FLIT_RC_W-1:0] f);
        return f[FLIT_RC_W-1:TGT_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upwards, wrapping, and moves the
// pointer just past the winner only when the grant is actually consumed (advance).
module rr_arbiter #(
    parameter  int N     = 7,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         gnt_valid
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        int               s;
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] win;
        grant     = '0;
        gnt_valid = 1'b0;
        win       = '0;
        idx       = '0;
        s         = 0;
        ptr_d     = ptr_q;
        for (int off = 0; off < N; off++) begin
            s = int'(ptr_q) + off;
            if (s >= N) s = s - N;
            idx = PTR_W'(s);
            if (!gnt_valid && req[idx]) begin
                gnt_valid  = 1'b1;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
        if (advance && gnt_valid)
            ptr_d = (win == PTR_W'(N-1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/switch_alloc_rr.sv
// Crossbar switch allocation: decodes each input's target, arbitrates per output
// round-robin, registers the winning flit (target stripped) and counts discarded flits.
module switch_alloc_rr
    import noc_pkg::*;
#(
    parameter int NUM_IN  = 7,
    parameter int NUM_OUT = 7,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLIT_RC_W*NUM_IN-1:0]  in_flit,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [FLIT_W*NUM_OUT-1:0]    out_flit,
    output logic [NUM_OUT-1:0]           out_valid,
    input  logic [NUM_OUT-1:0]           out_ready,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int DC_W  = $clog2(NUM_IN + 1);
    localparam int SUM_W = CNT_W + DC_W;

    logic [NUM_IN-1:0]  req   [NUM_OUT];
    logic [NUM_IN-1:0]  grant [NUM_OUT];
    logic [NUM_OUT-1:0] gnt_valid;
    logic [NUM_OUT-1:0] free;
    logic [NUM_IN-1:0]  drop;
    logic [NUM_IN-1:0]  accept;
    logic [DC_W-1:0]    n_drop;
    logic [SUM_W-1:0]   drop_sum;

    logic [FLIT_W-1:0]  out_flit_q [NUM_OUT];
    logic [FLIT_W-1:0]  out_flit_d [NUM_OUT];
    logic [NUM_OUT-1:0] out_valid_q, out_valid_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    // Target codes with no matching output are discarded rather than stalled.
    always_comb begin
        logic [TGT_W-1:0] tgt;
        tgt  = '0;
        drop = '0;
        for (int k = 0; k < NUM_OUT; k++) req[k] = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            tgt     = in_flit[FLIT_RC_W*i +: TGT_W];
            drop[i] = in_valid[i] && ((tgt == TGT_NONE) || (int'(tgt) > NUM_OUT));
            for (int k = 0; k < NUM_OUT; k++)
                req[k][i] = in_valid[i] && (int'(tgt) == k + 1);
        end
    end

    assign free = ~out_valid_q | out_ready;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_arb
        rr_arbiter #(.N(NUM_IN)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (req[k]),
            .advance   (free[k]),
            .grant     (grant[k]),
            .gnt_valid (gnt_valid[k])
        );
        assign out_flit[FLIT_W*k +: FLIT_W] = out_flit_q[k];
    end

    always_comb begin
        accept = drop;
        for (int k = 0; k < NUM_OUT; k++)
            accept = accept | (grant[k] & {NUM_IN{free[k]}});
    end

    assign in_ready = rst ? '0 : accept;

    always_comb begin
        out_valid_d = out_valid_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_flit_d[k] = out_flit_q[k];
            if (free[k] && gnt_valid[k]) begin
                out_valid_d[k] = 1'b1;
                for (int i = 0; i < NUM_IN; i++)
                    if (grant[k][i])
                        out_flit_d[k] = strip_target(in_flit[FLIT_RC_W*i +: FLIT_RC_W]);
            end else if (out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
    end

    // Several inputs may drop in one cycle; the counter adds them all and saturates.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_IN; i++)
            n_drop = n_drop + DC_W'(drop[i]);
        drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(n_drop);
        if (drop_sum > SUM_W'({CNT_W{1'b1}}))
            drop_cnt_d = '1;
        else
            drop_cnt_d = drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            drop_cnt_q  <= '0;
            for (int k = 0; k < NUM_OUT; k++) out_flit_q[k] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int k = 0; k < NUM_OUT; k++) out_flit_q[k] <= out_flit_d[k];
        end
    end

    assign out_valid = out_valid_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Randomised and directed bench for switch_alloc_rr against an array-based reference model.
module tb_switch_alloc_rr;

    localparam int NI = 7;
    localparam int NO = 7;
    localparam int CW = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [23*NI-1:0]   in_flit;
    logic [NI-1:0]      in_valid;
    logic [NI-1:0]      in_ready;
    logic [20*NO-1:0]   out_flit;
    logic [NO-1:0]      out_valid;
    logic [NO-1:0]      out_ready;
    logic [CW-1:0]      drop_cnt;

    switch_alloc_rr #(.NUM_IN(NI), .NUM_OUT(NO), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;

    logic [22:0] s_flit  [NI];
    bit          s_valid [NI];
    bit          m_valid [NO];
    logic [19:0] m_flit  [NO];
    int          m_ptr   [NO];
    int          m_drops;
    int          exp_win [NO];
    logic [NI-1:0] exp_ready;
    logic [NI-1:0] last_ready;
    int          seq [6] = '{0, 3, 5, 0, 3, 5};

    task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec rule: each free output picks the first requester at or after its pointer.
    function automatic void modelArbitrate();
        int t;
        int i;
        for (int k = 0; k < NO; k++) begin
            exp_win[k] = -1;
            if (!m_valid[k] || out_ready[k])
                for (int off = 0; off < NI; off++) begin
                    i = (m_ptr[k] + off) % NI;
                    if (exp_win[k] < 0 && s_valid[i] && int'(s_flit[i][2:0]) == k + 1)
                        exp_win[k] = i;
                end
        end
        exp_ready = '0;
        for (int j = 0; j < NI; j++) begin
            t = int'(s_flit[j][2:0]);
            if (s_valid[j] && (t == 0 || t > NO)) exp_ready[j] = 1'b1;
        end
        for (int k = 0; k < NO; k++)
            if (exp_win[k] >= 0) exp_ready[exp_win[k]] = 1'b1;
    endfunction

    function automatic void modelCommit();
        int nd;
        nd = 0;
        for (int j = 0; j < NI; j++)
            if (s_valid[j] && (s_flit[j][2:0] == 3'd0)) nd++;
        for (int k = 0; k < NO; k++) begin
            if (exp_win[k] >= 0) begin
                m_valid[k] = 1'b1;
                m_flit[k]  = s_flit[exp_win[k]][22:3];
                m_ptr[k]   = (exp_win[k] + 1) % NI;
            end else if (out_ready[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
        for (int j = 0; j < NI; j++)
            if (exp_ready[j]) s_valid[j] = 1'b0;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < NO; k++) begin
            m_valid[k] = 1'b0;
            m_flit[k]  = '0;
            m_ptr[k]   = 0;
        end
        for (int j = 0; j < NI; j++) begin
            s_valid[j] = 1'b0;
            s_flit[j]  = '0;
        end
        m_drops = 0;
    endfunction

    function automatic logic [20*NO-1:0] expFlits();
        logic [20*NO-1:0] r;
        for (int k = 0; k < NO; k++) r[20*k +: 20] = m_flit[k];
        return r;
    endfunction

    function automatic logic [NO-1:0] expValid();
        logic [NO-1:0] r;
        for (int k = 0; k < NO; k++) r[k] = m_valid[k];
        return r;
    endfunction

    // One clock: drive the sources, check everything against the model, then advance it.
    task automatic runCycle();
        for (int j = 0; j < NI; j++) begin
            in_flit[23*j +: 23] = s_flit[j];
            in_valid[j]         = s_valid[j];
        end
        #2;
        modelArbitrate();
        last_ready = in_ready;
        checkOutput("in_ready",  160'(in_ready),  160'(exp_ready));
        checkOutput("out_valid", 160'(out_valid), 160'(expValid()));
        checkOutput("out_flit",  160'(out_flit),  160'(expFlits()));
        checkOutput("drop_cnt",  160'(drop_cnt),  160'(m_drops));
        @(posedge clk);
        modelCommit();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] payload, input logic [3:0] dest,
                                 input logic [2:0] tgt);
        s_valid[idx] = 1'b1;
        s_flit[idx]  = {payload, dest, tgt};
    endtask

    task automatic flush();
        out_ready = '1;
        for (int c = 0; c < 10; c++) runCycle();
    endtask

    initial begin
        logic [31:0] r;
        rst       = 1'b1;
        in_flit   = '0;
        in_valid  = '0;
        out_ready = '0;
        modelReset();
        @(negedge clk);
        #1;
        checkOutput("reset_in_ready",  160'(in_ready),  160'(0));
        checkOutput("reset_out_valid", 160'(out_valid), 160'(0));
        checkOutput("reset_out_flit",  160'(out_flit),  160'(0));
        checkOutput("reset_drop_cnt",  160'(drop_cnt),  160'(0));
        @(negedge clk);
        rst = 1'b0;

        // single flit to target 3
        out_ready = '1;
        applyStimulus(0, 16'hBEEF, 4'b0110, 3'd3);
        runCycle();
        checkOutput("t1_ready", 160'(last_ready), 160'(7'b0000001));
        checkOutput("t1_valid", 160'(out_valid[2]), 160'(1));
        checkOutput("t1_flit",  160'(out_flit[40 +: 20]), 160'(20'hBEEF6));
        flush();

        // three-way contention on output 0
        for (int c = 0; c < 6; c++) begin
            if (!s_valid[0]) applyStimulus(0, 16'(c), 4'h0, 3'd1);
            if (!s_valid[3]) applyStimulus(3, 16'(c), 4'h3, 3'd1);
            if (!s_valid[5]) applyStimulus(5, 16'(c), 4'h5, 3'd1);
            runCycle();
            checkOutput("t2_order", 160'(last_ready), 160'(1 << seq[c]));
        end
        flush();

        // backpressure on output 1
        out_ready = '1;
        applyStimulus(2, 16'hAAAA, 4'h1, 3'd2);
        runCycle();
        out_ready[1] = 1'b0;
        applyStimulus(2, 16'h5555, 4'h2, 3'd2);
        for (int c = 0; c < 5; c++) begin
            runCycle();
            checkOutput("t3_stall_ready", 160'(last_ready[2]), 160'(0));
            checkOutput("t3_stall_flit",  160'(out_flit[20 +: 20]), 160'(20'hAAAA1));
        end
        out_ready[1] = 1'b1;
        runCycle();
        checkOutput("t3_release_ready", 160'(last_ready[2]), 160'(1));
        checkOutput("t3_release_flit",  160'(out_flit[20 +: 20]), 160'(20'h55552));
        flush();

        // parallel grants with output 3 stalled
        out_ready    = '1;
        out_ready[3] = 1'b0;
        applyStimulus(0, 16'h1111, 4'h0, 3'd4);
        applyStimulus(1, 16'h2222, 4'h0, 3'd7);
        applyStimulus(2, 16'h3333, 4'h0, 3'd1);
        runCycle();
        checkOutput("t4_ready",  160'(last_ready), 160'(7'b0000111));
        checkOutput("t4_valid",  160'(out_valid & 7'b1001001), 160'(7'b1001001));
        applyStimulus(0, 16'h4444, 4'h0, 3'd4);
        applyStimulus(1, 16'h5555, 4'h0, 3'd7);
        applyStimulus(2, 16'h6666, 4'h0, 3'd1);
        runCycle();
        checkOutput("t4_indep", 160'(last_ready), 160'(7'b0000110));
        flush();

        // drops and saturation
        applyStimulus(1, 16'h0, 4'h0, 3'd0);
        applyStimulus(4, 16'h0, 4'h0, 3'd0);
        applyStimulus(6, 16'h0, 4'h0, 3'd0);
        runCycle();
        checkOutput("t5_ready", 160'(last_ready), 160'(7'b1010010));
        checkOutput("t5_cnt3",  160'(drop_cnt), 160'(3));
        for (int c = 0; c < 40; c++) begin
            for (int j = 0; j < NI; j++) applyStimulus(j, 16'(c), 4'h0, 3'd0);
            runCycle();
        end
        checkOutput("t5_sat", 160'(drop_cnt), 160'(255));

        // randomised traffic
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < NI; j++)
                if (!s_valid[j] && ($urandom_range(0, 2) != 0)) begin
                    r = $urandom;
                    applyStimulus(j, r[15:0], r[19:16], 3'($urandom_range(0, 7)));
                end
            for (int k = 0; k < NO; k++) out_ready[k] = ($urandom_range(0, 9) < 7);
            runCycle();
        end
        flush();

        // asynchronous reset with every output full
        out_ready = '0;
        for (int j = 0; j < NI; j++) applyStimulus(j, 16'(j), 4'h0, 3'(j + 1));
        runCycle();
        checkOutput("t6_full", 160'(out_valid), 160'(7'h7F));
        #3;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_valid", 160'(out_valid), 160'(0));
        checkOutput("t6_async_cnt",   160'(drop_cnt),  160'(0));
        checkOutput("t6_async_ready", 160'(in_ready),  160'(0));
        modelReset();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = '1;
        applyStimulus(4, 16'h4444, 4'h0, 3'd1);
        applyStimulus(0, 16'h0000, 4'h0, 3'd1);
        runCycle();
        checkOutput("t6_ptr0", 160'(last_ready), 160'(7'b0000001));
        runCycle();
        checkOutput("t6_next", 160'(last_ready), 160'(7'b0010000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
